accum_drain_ctrl: RTL and testbench

//  Read-out sequencer downstream of the accumulator. Per start command, issues rd_len consecutive

---
 rtl/accum_pkg.sv | 34 +++
 rtl/accum_drain_ctrl_if.sv | 51 +++++
 rtl/accum_drain_fifo.sv | 58 +++++
 rtl/accum_drain_ctrl.sv | 155 +++++++++++++++
 tb/tb_accum_drain_ctrl.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator read-out sequencer.
// Holds the block geometry, the drain FSM state encoding, the FIFO beat
// layout and the lane-masking helper used on the return path.
package accum_pkg;

    localparam int NUM_BANKS  = 4;
    localparam int ADDR_WIDTH = 9;
    localparam int ZONE_WIDTH = 2;
    localparam int DATA_WIDTH = 64;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1;
    localparam int ROW_WIDTH  = NUM_BANKS * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} drain_state_e;

    typedef struct packed {
        logic                                 last;
        logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] data;
    } drain_beat_t;

    // Zero every bank lane whose mask bit is clear.
    function automatic logic [ROW_WIDTH-1:0] mask_lanes(
        input logic [ROW_WIDTH-1:0] row,
        input logic [NUM_BANKS-1:0] mask
    );
        logic [ROW_WIDTH-1:0] res;
        res = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            res[b*DATA_WIDTH +: DATA_WIDTH] = mask[b] ? row[b*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/accum_drain_ctrl_if.sv
// Channel bundle of the read-out sequencer.
//   start_*  : drain request (valid/ready), zone, bank mask, first row, row count
//   rd_*     : read command towards the accumulator (valid/ready)
//   rvalid/rdata : read return, no backpressure
//   out_*    : beat stream towards the store/pack unit (valid/ready, last)
// The slave modport is the sequencer side, master is the surrounding system.
interface accum_drain_ctrl_if;
    import accum_pkg::*;

    logic                  start_valid;
    logic                  start_ready;
    logic [ZONE_WIDTH-1:0] start_zone_id;
    logic [NUM_BANKS-1:0]  start_mask;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [ADDR_WIDTH:0]   start_len;

    logic                  rd_valid;
    logic                  rd_ready;
    logic [ZONE_WIDTH-1:0] rd_zone_id;
    logic [NUM_BANKS-1:0]  rd_mask;
    logic [ADDR_WIDTH-1:0] rd_addr;

    logic                  rvalid;
    logic [ROW_WIDTH-1:0]  rdata;

    logic                  out_valid;
    logic                  out_ready;
    logic [ROW_WIDTH-1:0]  out_data;
    logic                  out_last;

    modport slave (
        input  start_valid, start_zone_id, start_mask, start_addr, start_len,
        output start_ready,
        output rd_valid, rd_zone_id, rd_mask, rd_addr,
        input  rd_ready,
        input  rvalid, rdata,
        output out_valid, out_data, out_last,
        input  out_ready
    );

    modport master (
        output start_valid, start_zone_id, start_mask, start_addr, start_len,
        input  start_ready,
        input  rd_valid, rd_zone_id, rd_mask, rd_addr,
        output rd_ready,
        output rvalid, rdata,
        input  out_valid, out_data, out_last,
        output out_ready
    );

endinterface

// File: rtl/accum_drain_fifo.sv
// Synchronous FIFO holding returned read beats.
// Ports: clk, rst (async, active-high), push/push_data, pop/pop_data,
//        full, empty, count (occupancy, 0..DEPTH).
// pop_data is read straight from storage, so a beat written on one edge is
// visible from the next cycle on and stays stable until it is popped.
module accum_drain_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    // A push while full is accepted only when a pop frees the slot that cycle.
    assign do_push  = push && (!full || pop);
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/accum_drain_ctrl.sv
// Accumulator read-out sequencer.
// Ports: clk, rst (async, active-high); bus (slave side of the start, read
//        command, read return and output beat channels); busy (not IDLE);
//        done (one-cycle pulse at drain completion); err (sticky, read data
//        arrived with nothing outstanding, cleared when a start is accepted).
// Read commands are throttled by a credit count so that every outstanding
// read already owns a FIFO slot; returns can therefore never be refused.
module accum_drain_ctrl
    import accum_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    accum_drain_ctrl_if.slave   bus,
    output logic                busy,
    output logic                done,
    output logic                err
);
    drain_state_e          state;
    drain_state_e          state_nxt;

    logic [ZONE_WIDTH-1:0] zone_q;
    logic [NUM_BANKS-1:0]  mask_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   issued;
    logic [ADDR_WIDTH:0]   ret_cnt;
    logic [CNT_WIDTH-1:0]  outstanding;
    logic [CNT_WIDTH-1:0]  fifo_count;

    logic                  start_ready_c;
    logic                  rd_valid_c;
    logic                  start_fire;
    logic                  rd_fire;
    logic                  ret_ok;
    logic                  pop_fire;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  credit_ok;
    logic [CNT_WIDTH:0]    credit_used;
    drain_beat_t           push_beat;
    drain_beat_t           pop_beat;

    // Slots already spoken for: beats waiting in the FIFO plus reads in flight.
    assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
    assign credit_ok   = credit_used < (CNT_WIDTH + 1)'(FIFO_DEPTH);

    assign start_fire  = bus.start_valid && start_ready_c;
    assign rd_fire     = rd_valid_c && bus.rd_ready;
    assign ret_ok      = bus.rvalid && (outstanding != '0);
    assign pop_fire    = bus.out_ready && !fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        start_ready_c = 1'b0;
        rd_valid_c    = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        case (state)
            IDLE: begin
                start_ready_c = 1'b1;
                busy          = 1'b0;
                if (bus.start_valid) begin
                    state_nxt = (bus.start_len == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                rd_valid_c = credit_ok;
                if (rd_valid_c && bus.rd_ready && (issued == len_q - 1'b1)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop_fire && pop_beat.last) state_nxt = FINISH;
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zone_q      <= '0;
            mask_q      <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            issued      <= '0;
            ret_cnt     <= '0;
            outstanding <= '0;
            err         <= 1'b0;
        end else begin
            if (start_fire) begin
                zone_q  <= bus.start_zone_id;
                mask_q  <= bus.start_mask;
                addr_q  <= bus.start_addr;
                len_q   <= bus.start_len;
                issued  <= '0;
                ret_cnt <= '0;
            end else begin
                if (rd_fire) begin
                    addr_q <= addr_q + 1'b1;
                    issued <= issued + 1'b1;
                end
                if (ret_ok) ret_cnt <= ret_cnt + 1'b1;
            end
            case ({rd_fire, ret_ok})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            // A stray return wins over the clear so it is never hidden.
            if (bus.rvalid && (outstanding == '0)) err <= 1'b1;
            else if (start_fire)                   err <= 1'b0;
        end
    end

    assign push_beat.last = (ret_cnt == len_q - 1'b1);
    assign push_beat.data = mask_lanes(bus.rdata, mask_q);

    accum_drain_fifo #(
        .WIDTH ($bits(drain_beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ret_ok),
        .push_data (push_beat),
        .pop       (pop_fire),
        .pop_data  (pop_beat),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // The credit rule must make a push into a full FIFO impossible.
    assert property (@(posedge clk) disable iff (rst) !(fifo_full && ret_ok && !pop_fire));

    assign bus.start_ready = start_ready_c;
    assign bus.rd_valid    = rd_valid_c;
    assign bus.rd_zone_id  = zone_q;
    assign bus.rd_mask     = mask_q;
    assign bus.rd_addr     = addr_q;
    assign bus.out_valid   = !fifo_empty;
    // Storage is not reset, so beat fields are forced to zero while empty.
    assign bus.out_data    = fifo_empty ? '0 : pop_beat.data;
    assign bus.out_last    = !fifo_empty && pop_beat.last;

endmodule

// File: tb/tb_accum_drain_ctrl.sv
module tb_accum_drain_ctrl;
    import accum_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic busy, done, err;

    always #5 clk = ~clk;

    accum_drain_ctrl_if bus ();

    accum_drain_ctrl dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    typedef struct {
        logic [8:0] addr;
        logic [1:0] zone;
        logic [3:0] mask;
    } cmd_t;

    typedef struct {
        logic [255:0] data;
        logic         last;
    } beat_t;

    cmd_t  cmd_q  [$];
    beat_t beat_q [$];

    int checks       = 0;
    int failures     = 0;
    int rd_fires     = 0;
    int out_beats    = 0;
    int cyc          = 0;
    int last_pop_cyc = -10;
    bit data_ones    = 1'b0;
    bit inject       = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] lane_pat(input logic [8:0] a, input int b);
        return {32'hDA7A_0000 | 32'(b), 23'h0, a};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Accumulator model: two-cycle read latency, plus optional stray return.
    logic       st_v, p1_v = 1'b0, p2_v = 1'b0;
    logic [8:0] st_a, p1_a = '0, p2_a = '0;
    initial begin
        logic [255:0] row;
        bus.rvalid = 1'b0;
        bus.rdata  = '0;
        forever begin
            @(negedge clk);
            st_v = bus.rd_valid && bus.rd_ready;
            st_a = bus.rd_addr;
            @(posedge clk);
            #1;
            for (int b = 0; b < 4; b++) row[b*64 +: 64] = data_ones ? {64{1'b1}} : lane_pat(p2_a, b);
            bus.rvalid = p2_v | inject;
            bus.rdata  = row;
            p2_v = p1_v; p2_a = p1_a;
            p1_v = st_v; p1_a = st_a;
        end
    end

    // Scoreboard monitors.
    cmd_t  mc;
    beat_t mb;
    always @(negedge clk) begin
        if (bus.rd_valid && bus.rd_ready) begin
            rd_fires++;
            if (cmd_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL rd_cmd_unexpected: got addr %0d expected no command", bus.rd_addr);
            end else begin
                mc = cmd_q.pop_front();
                chk("rd_addr", bus.rd_addr, mc.addr);
                chk("rd_zone_id", bus.rd_zone_id, mc.zone);
                chk("rd_mask", bus.rd_mask, mc.mask);
            end
        end
        if (bus.out_valid && bus.out_ready) begin
            out_beats++;
            if (bus.out_last) last_pop_cyc = cyc;
            if (beat_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL out_beat_unexpected: got data %0h expected no beat", bus.out_data);
            end else begin
                mb = beat_q.pop_front();
                chk("out_data", bus.out_data, mb.data);
                chk("out_last", bus.out_last, mb.last);
            end
        end
    end

    task automatic push_cmds(input logic [1:0] z, input logic [3:0] m, input logic [8:0] a, input int l);
        for (int i = 0; i < l; i++) cmd_q.push_back('{addr: a + 9'(i), zone: z, mask: m});
    endtask

    task automatic push_beats(input logic [3:0] m, input logic [8:0] a, input int l);
        beat_t bt;
        for (int i = 0; i < l; i++) begin
            for (int b = 0; b < 4; b++) bt.data[b*64 +: 64] = m[b] ? lane_pat(a + 9'(i), b) : 64'h0;
            bt.last = (i == l - 1);
            beat_q.push_back(bt);
        end
    endtask

    task automatic start_drain(input logic [1:0] z, input logic [3:0] m, input logic [8:0] a, input logic [9:0] l);
        int n;
        @(posedge clk); #1;
        bus.start_valid = 1'b1; bus.start_zone_id = z; bus.start_mask = m;
        bus.start_addr = a; bus.start_len = l;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.start_ready) break;
        end
        if (n == 50) begin
            checks++; failures++;
            $display("FAIL start_accept_timeout: got start_ready 0 expected 1");
        end
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        chk("busy_after_accept", busy, 1'b1);
        chk("start_ready_after_accept", bus.start_ready, 1'b0);
    endtask

    task automatic wait_done(input string name, input int limit, input bit timing);
        int n;
        for (n = 0; n < limit; n++) begin
            @(negedge clk);
            if (done) break;
        end
        if (n == limit) begin
            checks++; failures++;
            $display("FAIL %s_done_timeout: got no done expected pulse", name);
        end else begin
            if (timing) chk({name, "_done_after_last_pop"}, cyc, last_pop_cyc + 1);
            chk({name, "_start_ready_in_finish"}, bus.start_ready, 1'b0);
            @(negedge clk);
            chk({name, "_done_one_cycle"}, done, 1'b0);
            chk({name, "_idle_start_ready"}, bus.start_ready, 1'b1);
            chk({name, "_idle_busy"}, busy, 1'b0);
            chk({name, "_beats_left"}, beat_q.size(), 0);
            chk({name, "_cmds_left"}, cmd_q.size(), 0);
        end
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_start_ready"}, bus.start_ready, 1'b1);
        chk({name, "_rd_valid"}, bus.rd_valid, 1'b0);
        chk({name, "_out_valid"}, bus.out_valid, 1'b0);
        chk({name, "_out_last"}, bus.out_last, 1'b0);
        chk({name, "_busy"}, busy, 1'b0);
        chk({name, "_done"}, done, 1'b0);
        chk({name, "_err"}, err, 1'b0);
        chk({name, "_rd_addr"}, bus.rd_addr, 9'd0);
        chk({name, "_rd_zone_id"}, bus.rd_zone_id, 2'd0);
        chk({name, "_rd_mask"}, bus.rd_mask, 4'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, b0, n;
        logic [255:0] snap;
        beat_t bt;
        rst = 1'b1;
        bus.start_valid = 1'b0; bus.start_zone_id = '0; bus.start_mask = '0;
        bus.start_addr = '0; bus.start_len = '0;
        bus.rd_ready = 1'b1; bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("post_reset");

        // 1: full-mask drain of 8 rows from address 0
        push_cmds(2'd1, 4'b1111, 9'd0, 8);
        push_beats(4'b1111, 9'd0, 8);
        f0 = rd_fires; b0 = out_beats;
        start_drain(2'd1, 4'b1111, 9'd0, 10'd8);
        wait_done("t1", 200, 1'b1);
        chk("t1_rd_count", rd_fires - f0, 8);
        chk("t1_beat_count", out_beats - b0, 8);

        // 2: sparse mask with all-ones read data
        data_ones = 1'b1;
        push_cmds(2'd0, 4'b0101, 9'd20, 2);
        bt.data = {64'h0, {64{1'b1}}, 64'h0, {64{1'b1}}};
        bt.last = 1'b0; beat_q.push_back(bt);
        bt.last = 1'b1; beat_q.push_back(bt);
        start_drain(2'd0, 4'b0101, 9'd20, 10'd2);
        wait_done("t2", 100, 1'b1);
        data_ones = 1'b0;

        // 3: downstream stalled, credit throttling
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        push_cmds(2'd2, 4'b1111, 9'd100, 16);
        push_beats(4'b1111, 9'd100, 16);
        f0 = rd_fires;
        start_drain(2'd2, 4'b1111, 9'd100, 10'd16);
        repeat (20) @(negedge clk);
        chk("t3_rd_stall_count", rd_fires - f0, 4);
        chk("t3_rd_valid_stalled", bus.rd_valid, 1'b0);
        chk("t3_out_valid", bus.out_valid, 1'b1);
        snap = bus.out_data;
        repeat (3) @(negedge clk);
        chk("t3_out_data_stable", bus.out_data, snap);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_done("t3", 300, 1'b1);
        chk("t3_rd_total", rd_fires - f0, 16);

        // 4: address wrap 510, 511, 0, 1
        cmd_q.push_back('{addr: 9'd510, zone: 2'd3, mask: 4'b1000});
        cmd_q.push_back('{addr: 9'd511, zone: 2'd3, mask: 4'b1000});
        cmd_q.push_back('{addr: 9'd0,   zone: 2'd3, mask: 4'b1000});
        cmd_q.push_back('{addr: 9'd1,   zone: 2'd3, mask: 4'b1000});
        bt.data = '0; bt.data[255:192] = 64'hDA7A_0003_0000_01FE; bt.last = 1'b0; beat_q.push_back(bt);
        bt.data[255:192] = 64'hDA7A_0003_0000_01FF; beat_q.push_back(bt);
        bt.data[255:192] = 64'hDA7A_0003_0000_0000; beat_q.push_back(bt);
        bt.data[255:192] = 64'hDA7A_0003_0000_0001; bt.last = 1'b1; beat_q.push_back(bt);
        start_drain(2'd3, 4'b1000, 9'd510, 10'd4);
        wait_done("t4", 100, 1'b1);

        // 5: zero-length drain, then stray return in IDLE
        f0 = rd_fires; b0 = out_beats;
        start_drain(2'd0, 4'b1111, 9'd7, 10'd0);
        wait_done("t5", 20, 1'b0);
        chk("t5_no_reads", rd_fires - f0, 0);
        chk("t5_no_beats", out_beats - b0, 0);
        chk("t5_err_before", err, 1'b0);
        @(negedge clk); inject = 1'b1;
        @(negedge clk); inject = 1'b0;
        @(negedge clk);
        chk("t5_err_set", err, 1'b1);
        repeat (3) @(negedge clk);
        chk("t5_err_sticky", err, 1'b1);

        // 6: reset with two reads outstanding
        push_cmds(2'd1, 4'b1111, 9'd300, 8);
        push_beats(4'b1111, 9'd300, 8);
        f0 = rd_fires;
        start_drain(2'd1, 4'b1111, 9'd300, 10'd8);
        chk("t6_err_cleared_on_accept", err, 1'b0);
        for (n = 0; n < 50; n++) begin
            @(negedge clk); #1;
            if (rd_fires - f0 >= 2) break;
        end
        chk("t6_two_issued", rd_fires - f0, 2);
        @(posedge clk); #1;
        cmd_q.delete();
        beat_q.delete();
        rst = 1'b1;
        #1;
        chk_reset_vals("t6_mid_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_late_rvalid_err", err, 1'b1);
        chk("t6_idle_after_reset", bus.start_ready, 1'b1);
        push_cmds(2'd2, 4'b0011, 9'd40, 3);
        push_beats(4'b0011, 9'd40, 3);
        start_drain(2'd2, 4'b0011, 9'd40, 10'd3);
        chk("t6_err_cleared_again", err, 1'b0);
        wait_done("t6", 100, 1'b1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
